// File: rtl/uflash_pkg.sv
// rtl/uflash_pkg.sv - shared types and delay conversion for the user flash sequencer
package uflash_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_PROG  = 2'd1,
        OP_ERASE = 2'd2,
        OP_RSVD  = 2'd3
    } uf_op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SE,
        ST_RD_ACC,
        ST_NVS,
        ST_NVSTR,
        ST_PGM,
        ST_ADH,
        ST_NVH,
        ST_RCV,
        ST_NOP,
        ST_DONE
    } uf_state_t;

    localparam int DLY_W = 24;
    localparam logic [63:0] DLY_MAX_CYC = 64'd1 << DLY_W;

    // Round up so a timing minimum is never violated; a zero-length wait still costs one cycle.
    function automatic logic [63:0] us_to_cyc(input logic [63:0] hz, input logic [63:0] us);
        logic [63:0] c;
        c = (hz * us + 64'd999_999) / 64'd1_000_000;
        return (c == 64'd0) ? 64'd1 : c;
    endfunction

endpackage

// File: rtl/uflash_delay.sv
// rtl/uflash_delay.sv - shared down-counter timing every wait state of the sequencer
module uflash_delay
    import uflash_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DLY_W-1:0] value,
    output logic             expire
);

    logic [DLY_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/uflash_ctrl.sv
// rtl/uflash_ctrl.sv - READ/PROG/ERASE pin sequencer for the GW1N user flash
module uflash_ctrl
    import uflash_pkg::*;
#(
    parameter int unsigned CLOCK_HZ   = 27_000_000,
    parameter int unsigned T_NVS_US   = 5,
    parameter int unsigned T_PGS_US   = 10,
    parameter int unsigned T_PROG_US  = 16,
    parameter int unsigned T_NVH_US   = 5,
    parameter int unsigned T_RCV_US   = 10,
    parameter int unsigned T_ERASE_MS = 100,
    parameter int unsigned T_ACC_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_xadr,
    input  logic [5:0]  cmd_yadr,
    input  logic [31:0] cmd_wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic [8:0]  uf_xadr,
    output logic [5:0]  uf_yadr,
    output logic        uf_xe,
    output logic        uf_ye,
    output logic        uf_se,
    output logic        uf_erase,
    output logic        uf_prog,
    output logic        uf_nvstr,
    output logic [31:0] uf_din,
    input  logic [31:0] uf_dout
);

    localparam logic [63:0] NVS_CYC   = us_to_cyc(64'(CLOCK_HZ), 64'(T_NVS_US));
    localparam logic [63:0] PGS_CYC   = us_to_cyc(64'(CLOCK_HZ), 64'(T_PGS_US));
    localparam logic [63:0] PROG_CYC  = us_to_cyc(64'(CLOCK_HZ), 64'(T_PROG_US));
    localparam logic [63:0] NVH_CYC   = us_to_cyc(64'(CLOCK_HZ), 64'(T_NVH_US));
    localparam logic [63:0] RCV_CYC   = us_to_cyc(64'(CLOCK_HZ), 64'(T_RCV_US));
    localparam logic [63:0] ERASE_CYC = us_to_cyc(64'(CLOCK_HZ), 64'(T_ERASE_MS) * 64'd1000);
    localparam logic [63:0] ACC_CYC   = (T_ACC_CYC == 0) ? 64'd1 : 64'(T_ACC_CYC);

    if (NVS_CYC > DLY_MAX_CYC || PGS_CYC > DLY_MAX_CYC || PROG_CYC > DLY_MAX_CYC ||
        NVH_CYC > DLY_MAX_CYC || RCV_CYC > DLY_MAX_CYC || ERASE_CYC > DLY_MAX_CYC ||
        ACC_CYC > DLY_MAX_CYC) begin : g_dly_overflow
        $error("uflash_ctrl: a flash timing does not fit the 24-bit delay counter");
    end

    localparam logic [DLY_W-1:0] NVS_LD   = DLY_W'(NVS_CYC - 64'd1);
    localparam logic [DLY_W-1:0] PGS_LD   = DLY_W'(PGS_CYC - 64'd1);
    localparam logic [DLY_W-1:0] PROG_LD  = DLY_W'(PROG_CYC - 64'd1);
    localparam logic [DLY_W-1:0] NVH_LD   = DLY_W'(NVH_CYC - 64'd1);
    localparam logic [DLY_W-1:0] RCV_LD   = DLY_W'(RCV_CYC - 64'd1);
    localparam logic [DLY_W-1:0] ERASE_LD = DLY_W'(ERASE_CYC - 64'd1);
    localparam logic [DLY_W-1:0] ACC_LD   = DLY_W'(ACC_CYC - 64'd1);

    uf_state_t        state;
    uf_op_t           op_q;
    uf_op_t           op_sel;
    logic             accept;
    logic             dly_load;
    logic             dly_expire;
    logic [DLY_W-1:0] dly_value;

    assign accept = cmd_valid & ready;
    assign op_sel = (state == ST_IDLE) ? uf_op_t'(cmd_op) : op_q;

    // The counter is loaded on the same edge the FSM moves, with the hold of the state being entered.
    assign dly_load = (state == ST_IDLE) ? accept : dly_expire;

    always_comb begin
        dly_value = '0;
        case (state)
            ST_IDLE:   if (op_sel == OP_PROG || op_sel == OP_ERASE) dly_value = NVS_LD;
            ST_RD_SE:  dly_value = ACC_LD;
            ST_NVS:    dly_value = (op_sel == OP_PROG) ? PGS_LD : ERASE_LD;
            ST_NVSTR:  dly_value = (op_sel == OP_PROG) ? PROG_LD : NVH_LD;
            ST_ADH:    dly_value = NVH_LD;
            ST_NVH:    dly_value = RCV_LD;
            default:   dly_value = '0;
        endcase
    end

    uflash_delay u_delay (
        .clk    (clk),
        .rst    (rst),
        .load   (dly_load),
        .value  (dly_value),
        .expire (dly_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_READ;
            ready    <= 1'b1;
            done     <= 1'b0;
            rdata    <= '0;
            uf_xadr  <= '0;
            uf_yadr  <= '0;
            uf_din   <= '0;
            uf_xe    <= 1'b0;
            uf_ye    <= 1'b0;
            uf_se    <= 1'b0;
            uf_erase <= 1'b0;
            uf_prog  <= 1'b0;
            uf_nvstr <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    ready   <= 1'b0;
                    op_q    <= uf_op_t'(cmd_op);
                    uf_xadr <= cmd_xadr;
                    uf_yadr <= cmd_yadr;
                    uf_din  <= cmd_wdata;
                    case (uf_op_t'(cmd_op))
                        OP_READ: begin
                            state <= ST_RD_SE;
                            uf_xe <= 1'b1;
                            uf_ye <= 1'b1;
                            uf_se <= 1'b1;
                        end
                        OP_PROG: begin
                            state   <= ST_NVS;
                            uf_xe   <= 1'b1;
                            uf_prog <= 1'b1;
                        end
                        OP_ERASE: begin
                            state    <= ST_NVS;
                            uf_xe    <= 1'b1;
                            uf_erase <= 1'b1;
                        end
                        default: state <= ST_NOP;
                    endcase
                end
            end else if (dly_expire) begin
                case (state)
                    ST_RD_SE: begin
                        state <= ST_RD_ACC;
                        uf_se <= 1'b0;
                    end
                    ST_RD_ACC: begin
                        state <= ST_DONE;
                        rdata <= uf_dout;
                        uf_xe <= 1'b0;
                        uf_ye <= 1'b0;
                        done  <= 1'b1;
                    end
                    ST_NVS: begin
                        state    <= ST_NVSTR;
                        uf_nvstr <= 1'b1;
                    end
                    ST_NVSTR: begin
                        if (op_q == OP_PROG) begin
                            state <= ST_PGM;
                            uf_ye <= 1'b1;
                        end else begin
                            state    <= ST_NVH;
                            uf_erase <= 1'b0;
                        end
                    end
                    ST_PGM: begin
                        state <= ST_ADH;
                        uf_ye <= 1'b0;
                    end
                    ST_ADH: begin
                        state   <= ST_NVH;
                        uf_prog <= 1'b0;
                    end
                    ST_NVH: begin
                        state    <= ST_RCV;
                        uf_nvstr <= 1'b0;
                    end
                    ST_RCV: begin
                        state    <= ST_DONE;
                        uf_xe    <= 1'b0;
                        uf_ye    <= 1'b0;
                        uf_se    <= 1'b0;
                        uf_erase <= 1'b0;
                        uf_prog  <= 1'b0;
                        uf_nvstr <= 1'b0;
                        done     <= 1'b1;
                    end
                    ST_NOP: begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uflash_ctrl.sv
// tb/tb_uflash_ctrl.sv - directed and randomized checks of uflash_ctrl against a flash model
module tb_uflash_ctrl;

    localparam int NVS = 5, PGS = 10, PRG = 16, NVH = 5, RCV = 10, ERS = 1000, ACC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [8:0]  cmd_xadr = '0;
    logic [5:0]  cmd_yadr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        ready, done;
    logic [31:0] rdata;
    logic [8:0]  uf_xadr;
    logic [5:0]  uf_yadr;
    logic        uf_xe, uf_ye, uf_se, uf_erase, uf_prog, uf_nvstr;
    logic [31:0] uf_din;
    logic [31:0] uf_dout;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;

    uflash_ctrl #(.CLOCK_HZ(1_000_000), .T_ERASE_MS(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_xadr(cmd_xadr), .cmd_yadr(cmd_yadr), .cmd_wdata(cmd_wdata),
        .ready(ready), .done(done), .rdata(rdata),
        .uf_xadr(uf_xadr), .uf_yadr(uf_yadr), .uf_xe(uf_xe), .uf_ye(uf_ye),
        .uf_se(uf_se), .uf_erase(uf_erase), .uf_prog(uf_prog), .uf_nvstr(uf_nvstr),
        .uf_din(uf_din), .uf_dout(uf_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Flash array as seen through the pins, and the command-level expectation of it.
    logic [31:0] fl_mem  [logic [14:0]];
    logic [31:0] ref_mem [logic [14:0]];
    logic [31:0] dout_q = '0;
    assign uf_dout = dout_q;

    function automatic logic [31:0] fl_rd(input logic [14:0] k);
        return fl_mem.exists(k) ? fl_mem[k] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [14:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk) begin
        if (uf_se) dout_q <= fl_rd({uf_xadr, uf_yadr});
        else if (!uf_xe) dout_q <= $urandom;
    end

    logic        clr_req = 1'b0;
    logic [31:0] din_exp = '0;
    logic [14:0] adr_exp = '0;
    logic        p_xe = 0, p_ye = 0, p_er = 0, p_pg = 0, p_nv = 0;
    int t_xe_r = -1, t_er_r = -1, t_pg_r = -1, t_nv_r = -1, t_ye_r = -1;
    int t_ye_f = -1, t_er_f = -1, t_pg_f = -1, t_nv_f = -1, t_done = -1;
    int n_se = 0, n_ye_r = 0, n_nv_r = 0, n_done = 0, n_xe = 0, n_bad = 0;

    always @(negedge clk) begin
        if (clr_req) begin
            t_xe_r = -1; t_er_r = -1; t_pg_r = -1; t_nv_r = -1; t_ye_r = -1;
            t_ye_f = -1; t_er_f = -1; t_pg_f = -1; t_nv_f = -1; t_done = -1;
            n_se = 0; n_ye_r = 0; n_nv_r = 0; n_done = 0; n_xe = 0; n_bad = 0;
        end else begin
            if (uf_xe && !p_xe && t_xe_r < 0) t_xe_r = cyc_n;
            if (uf_erase && !p_er && t_er_r < 0) t_er_r = cyc_n;
            if (uf_prog && !p_pg && t_pg_r < 0) t_pg_r = cyc_n;
            if (uf_nvstr && !p_nv && t_nv_r < 0) t_nv_r = cyc_n;
            if (uf_ye && !p_ye && t_ye_r < 0) t_ye_r = cyc_n;
            if (!uf_ye && p_ye && t_ye_f < 0) t_ye_f = cyc_n;
            if (!uf_erase && p_er && t_er_f < 0) t_er_f = cyc_n;
            if (!uf_prog && p_pg && t_pg_f < 0) t_pg_f = cyc_n;
            if (!uf_nvstr && p_nv && t_nv_f < 0) t_nv_f = cyc_n;
            if (done && t_done < 0) t_done = cyc_n;
            if (uf_se) n_se++;
            if (uf_ye && !p_ye) n_ye_r++;
            if (uf_nvstr && !p_nv) n_nv_r++;
            if (uf_xe) n_xe++;
            if (done) n_done++;
            if (uf_xe && (uf_din !== din_exp || {uf_xadr, uf_yadr} !== adr_exp)) n_bad++;
        end
        if (uf_xe && uf_prog && uf_nvstr && uf_ye && !p_ye)
            fl_mem[{uf_xadr, uf_yadr}] = fl_rd({uf_xadr, uf_yadr}) & uf_din;
        if (uf_xe && uf_erase && uf_nvstr && !p_nv)
            for (int y = 0; y < 64; y++) fl_mem.delete({uf_xadr, 6'(y)});
        {p_xe, p_ye, p_er, p_pg, p_nv} = {uf_xe, uf_ye, uf_erase, uf_prog, uf_nvstr};
    end

    logic [31:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            2'd0:    return 1 + 1 + ACC;
            2'd1:    return 1 + NVS + PGS + PRG + 1 + NVH + RCV;
            2'd2:    return 1 + NVS + ERS + NVH + RCV;
            default: return 2;
        endcase
    endfunction

    task automatic mon_clear(input logic [31:0] din, input logic [14:0] adr);
        din_exp = din;
        adr_exp = adr;
        clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [8:0] x, input logic [5:0] y,
                         input logic [31:0] d, output int acc);
        cmd_op = op; cmd_xadr = x; cmd_yadr = y; cmd_wdata = d; cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            if (ready) begin
                acc = cyc_n;
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                t = cyc_n;
                break;
            end
            @(negedge clk); #1;
        end
        if (t < 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [8:0] x, input logic [5:0] y,
                           input logic [31:0] d, output int acc);
        int td;
        mon_clear(d, {x, y});
        issue(op, x, y, d, acc);
        wait_done(2000, td);
        chk("latency", 32'(td - acc), 32'(exp_lat(op)));
        chk("done_once", 32'(n_done), 32'd1);
        chk("adr_din_stable", 32'(n_bad), 32'd0);
        case (op)
            2'd0: exp_rdata = ref_rd({x, y});
            2'd1: ref_mem[{x, y}] = ref_rd({x, y}) & d;
            2'd2: for (int i = 0; i < 64; i++) ref_mem.delete({x, 6'(i)});
            default: chk("rsvd_no_xe", 32'(n_xe), 32'd0);
        endcase
        chk("rdata", rdata, exp_rdata);
    endtask

    initial begin
        int acc, acc2, td;
        logic [1:0] op;
        int r;

        fl_mem[{9'd3, 6'd5}]  = 32'hDEAD_BEEF;
        ref_mem[{9'd3, 6'd5}] = 32'hDEAD_BEEF;
        fl_mem[{9'd2, 6'd0}]  = 32'h0F0F_0000;
        ref_mem[{9'd2, 6'd0}] = 32'h0F0F_0000;

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ctl", 32'({uf_xe, uf_ye, uf_se, uf_erase, uf_prog, uf_nvstr}), 32'd0);
        chk("rst_adr_din", uf_din | 32'({uf_xadr, uf_yadr}), 32'd0);

        run_cmd(2'd0, 9'd3, 6'd5, 32'h0, acc);
        chk("read_deadbeef", rdata, 32'hDEAD_BEEF);
        chk("read_se_width", 32'(n_se), 32'd1);
        chk("read_xe_start", 32'(t_xe_r - acc), 32'd1);

        run_cmd(2'd1, 9'd7, 6'd1, 32'h1234_5678, acc);
        chk("prog_with_xe", 32'(t_pg_r - t_xe_r), 32'd0);
        chk("prog_nvs", 32'(t_nv_r - t_pg_r), 32'(NVS));
        chk("prog_pgs", 32'(t_ye_r - t_nv_r), 32'(PGS));
        chk("prog_ye_width", 32'(t_ye_f - t_ye_r), 32'(PRG));
        chk("prog_adh", 32'(t_pg_f - t_ye_f), 32'd1);
        chk("prog_nvh", 32'(t_nv_f - t_pg_f), 32'(NVH));
        chk("prog_rcv", 32'(t_done - t_nv_f), 32'(RCV));
        chk("prog_no_se", 32'(n_se), 32'd0);

        run_cmd(2'd2, 9'd2, 6'd0, 32'h0, acc);
        chk("erase_with_xe", 32'(t_er_r - t_xe_r), 32'd0);
        chk("erase_nvs", 32'(t_nv_r - t_er_r), 32'(NVS));
        chk("erase_hold", 32'(t_er_f - t_nv_r), 32'(ERS));
        chk("erase_nvh", 32'(t_nv_f - t_er_f), 32'(NVH));
        chk("erase_no_ye_se", 32'(n_ye_r + n_se), 32'd0);
        run_cmd(2'd0, 9'd2, 6'd0, 32'h0, acc);
        chk("erase_readback", rdata, 32'hFFFF_FFFF);

        // Busy-time request must be dropped; the READ waiting behind it goes in on the first ready cycle.
        mon_clear(32'hABCD_0123, {9'd7, 6'd1});
        issue(2'd1, 9'd7, 6'd1, 32'hABCD_0123, acc);
        ref_mem[{9'd7, 6'd1}] = ref_rd({9'd7, 6'd1}) & 32'hABCD_0123;
        cmd_op = 2'd2;
        cmd_valid = 1'b1;
        td = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                td = cyc_n;
                break;
            end
            @(negedge clk); #1;
        end
        chk("hold_prog_latency", 32'(td - acc), 32'(exp_lat(2'd1)));
        cmd_op = 2'd0;
        @(negedge clk); #1;
        chk("b2b_ready", 32'(ready), 32'd1);
        acc2 = cyc_n;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        chk("hold_one_done", 32'(n_done), 32'd1);
        chk("hold_one_nvstr", 32'(n_nv_r), 32'd1);
        wait_done(50, td);
        chk("b2b_read_latency", 32'(td - acc2), 32'(exp_lat(2'd0)));
        exp_rdata = ref_rd({9'd7, 6'd1});
        chk("b2b_read_data", rdata, exp_rdata);

        run_cmd(2'd3, 9'd4, 6'd4, 32'h5555_AAAA, acc);

        mon_clear(32'h0, {9'd9, 6'd0});
        issue(2'd2, 9'd9, 6'd0, 32'h0, acc);
        for (int i = 0; i < 50 && !uf_nvstr; i++) begin
            @(negedge clk); #1;
        end
        chk("rst_test_nvstr", 32'(uf_nvstr), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst_ctl", 32'({uf_xe, uf_ye, uf_se, uf_erase, uf_prog, uf_nvstr}), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        chk("post_rst_ready", 32'(ready), 32'd1);
        exp_rdata = 32'd0;
        run_cmd(2'd0, 9'd7, 6'd1, 32'h0, acc);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            op = (r < 50) ? 2'd0 : (r < 85) ? 2'd1 : (r < 95) ? 2'd3 : 2'd2;
            run_cmd(op, 9'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), $urandom, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
